ram_stream_reader: RTL and testbench



---
 rtl/ram_stream_reader_pkg.sv | 13 +
 rtl/ram_stream_reader_if.sv | 10 +
 rtl/ram_stream_reader_stream_skid_fifo.sv | 58 +++++
 rtl/ram_stream_reader.sv | 106 ++++++++++
 tb/tb_ram_stream_reader.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/ram_stream_reader_pkg.sv
// Shared definitions for the RAM-to-AXI4-Stream burst reader.
package ram_stream_reader_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      FINISH = 2'd2
   } state_t;

   localparam int FIFO_DEPTH = 2;
   localparam int OCC_BITS   = $clog2(FIFO_DEPTH + 1);

endpackage

// File: rtl/ram_stream_reader_if.sv
// AXI4-Stream beat channel driven by the burst reader.
interface ram_stream_reader_if #(parameter int WIDTH = 8);
   logic [WIDTH-1:0] tdata;
   logic             tvalid;
   logic             tready;
   logic             tlast;

   modport master (output tdata, output tvalid, output tlast, input tready);
   modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/ram_stream_reader_stream_skid_fifo.sv
// Two-entry register FIFO; head entry is presented directly as stream data.
module stream_skid_fifo
   import ram_stream_reader_pkg::*;
#(
   parameter int width = 8
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic                wr_en,
   input  logic [width-1:0]    wr_data,
   input  logic                rd_en,
   output logic [width-1:0]    head,
   output logic [OCC_BITS-1:0] occ
);

   localparam logic [OCC_BITS-1:0] OCC_ONE  = OCC_BITS'(1);
   localparam logic [OCC_BITS-1:0] OCC_FULL = OCC_BITS'(FIFO_DEPTH);

   logic [width-1:0] tail;
   logic             do_rd;
   logic             do_wr;

   always_comb begin
      do_rd = rd_en && (occ != '0);
      do_wr = wr_en && ((occ != OCC_FULL) || do_rd);
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         head <= '0;
         tail <= '0;
         occ  <= '0;
      end else begin
         case ({do_wr, do_rd})
            2'b10: begin
               if (occ == '0) head <= wr_data;
               else           tail <= wr_data;
               occ <= occ + OCC_ONE;
            end
            2'b01: begin
               head <= tail;
               occ  <= occ - OCC_ONE;
            end
            2'b11: begin
               // simultaneous push/pop: occupancy unchanged, queue shifts
               if (occ == OCC_ONE) begin
                  head <= wr_data;
               end else begin
                  head <= tail;
                  tail <= wr_data;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/ram_stream_reader.sv
// Reads count words from a 1-cycle-latency RAM and streams them out as one AXIS burst.
//   state  | meaning
//   IDLE   | waiting for start; captures base_address/count
//   RUN    | issuing RAM reads and streaming beats
//   FINISH | done pulse for one cycle, then back to IDLE
module ram_stream_reader
   import ram_stream_reader_pkg::*;
#(
   parameter int width      = 8,
   parameter int depth_bits = 2
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  start,
   input  logic [depth_bits-1:0] base_address,
   input  logic [depth_bits:0]   count,
   output logic                  busy,
   output logic                  done,
   output logic                  read_en,
   output logic [depth_bits-1:0] read_address,
   input  logic [width-1:0]      read_data_in,
   ram_stream_reader_if.master   m_axis
);

   state_t                state;
   logic [depth_bits-1:0] addr;
   logic [depth_bits:0]   reads_left;
   logic [depth_bits:0]   beats;
   logic [depth_bits:0]   beats_inc;
   logic [depth_bits:0]   count_r;
   logic                  v1;
   logic [OCC_BITS-1:0]   occ;
   logic [width-1:0]      head;
   logic                  pop;
   logic [2:0]            projected;

   stream_skid_fifo #(.width(width)) u_fifo (
      .clk     (clk),
      .resetn  (resetn),
      .wr_en   (v1),
      .wr_data (read_data_in),
      .rd_en   (pop),
      .head    (head),
      .occ     (occ)
   );

   always_comb begin
      m_axis.tdata  = head;
      m_axis.tvalid = (occ != '0);
      beats_inc     = beats + 1'b1;
      m_axis.tlast  = m_axis.tvalid && (beats_inc == count_r);
      pop           = m_axis.tvalid && m_axis.tready;
      // words held or in flight after this cycle's pop must leave room for one more
      projected     = {1'b0, occ} + {2'b00, v1} - {2'b00, pop};
      read_en       = (state == RUN) && (reads_left != '0) && (projected <= 3'd1);
      read_address  = addr;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state      <= IDLE;
         addr       <= '0;
         reads_left <= '0;
         beats      <= '0;
         count_r    <= '0;
         v1         <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         v1   <= read_en;
         done <= 1'b0;
         if (read_en) begin
            addr       <= addr + 1'b1;
            reads_left <= reads_left - 1'b1;
         end
         if (pop) beats <= beats_inc;
         case (state)
            IDLE: begin
               if (start) begin
                  addr       <= base_address;
                  reads_left <= count;
                  count_r    <= count;
                  beats      <= '0;
                  if (count == '0) begin
                     state <= FINISH;
                     done  <= 1'b1;
                  end else begin
                     state <= RUN;
                     busy  <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (pop && m_axis.tlast) begin
                  state <= FINISH;
                  done  <= 1'b1;
                  busy  <= 1'b0;
               end
            end
            FINISH:  state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ram_stream_reader.sv
// Randomized and directed bursts against a queue-based model of the expected stream.
module tb_ram_stream_reader;

   logic       clk;
   logic       resetn;
   logic       start;
   logic [1:0] base_address;
   logic [2:0] count;
   logic       busy;
   logic       done;
   logic       read_en;
   logic [1:0] read_address;
   logic [7:0] read_data_in;

   logic [7:0] ram [4];
   logic [7:0] ram_q;

   int checks = 0;
   int errors = 0;

   ram_stream_reader_if #(.WIDTH(8)) axis ();

   ram_stream_reader #(.width(8), .depth_bits(2)) dut (
      .clk          (clk),
      .resetn       (resetn),
      .start        (start),
      .base_address (base_address),
      .count        (count),
      .busy         (busy),
      .done         (done),
      .read_en      (read_en),
      .read_address (read_address),
      .read_data_in (read_data_in),
      .m_axis       (axis)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) if (read_en) ram_q <= ram[read_address];
   assign read_data_in = ram_q;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // mode: 0 always ready, 1 fixed toggle pattern, 2 random, 3 stalled for 10 cycles
   task automatic run_burst(input int base, input int cnt, input int mode,
                            input bit repulse, input int abort_after);
      logic [7:0] exp_q [$];
      bit         pattern [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      int         reads = 0, pops = 0, cyc, first_valid = -1, last_hs = -1;
      bit         finished = 0, aborted = 0, stalled = 0, rd_now;
      logic [7:0] held_d = '0;
      logic       held_l = 1'b0;

      for (int i = 0; i < cnt; i++) exp_q.push_back(ram[(base + i) % 4]);

      @(negedge clk);
      start        = 1'b1;
      base_address = base[1:0];
      count        = cnt[2:0];
      axis.tready  = 1'b1;
      @(posedge clk);

      for (cyc = 1; cyc <= 200 && !finished; cyc++) begin
         @(negedge clk);
         start        = repulse && (cyc == 2);
         base_address = 2'd2;
         count        = 3'd1;
         case (mode)
            0:       axis.tready = 1'b1;
            1:       axis.tready = pattern[(cyc - 1) % 6];
            2:       axis.tready = 1'($urandom_range(0, 1));
            default: axis.tready = (cyc > 10);
         endcase
         #1;
         rd_now = read_en;
         if (read_en) begin
            check("read_address", read_address, (base + reads) % 4);
            reads++;
         end
         if (axis.tvalid) begin
            if (first_valid < 0) first_valid = cyc;
            if (stalled) begin
               check("hold_tdata", axis.tdata, held_d);
               check("hold_tlast", axis.tlast, held_l);
            end
            if (axis.tready) begin
               check("beat_index", pops < cnt, 1);
               if (pops < cnt) begin
                  check("beat_tdata", axis.tdata, exp_q[pops]);
                  check("beat_tlast", axis.tlast, pops == cnt - 1);
               end
               pops++;
               last_hs = cyc;
               stalled = 0;
            end else begin
               stalled = 1;
               held_d  = axis.tdata;
               held_l  = axis.tlast;
            end
         end
         if (rd_now) check("read_rule", (reads - pops) <= 2, 1);
         if (mode == 3 && cyc == 10) check("stall_reads", reads, 2);
         if (done) begin
            finished = 1;
            check("done_cycle", cyc, (cnt == 0) ? 1 : last_hs + 1);
            check("beat_count", pops, cnt);
            check("read_count", reads, cnt);
            check("busy_at_done", busy, 0);
         end else begin
            check("busy", busy, cnt != 0);
         end
         if (!finished && abort_after >= 0 && pops == abort_after) begin
            @(posedge clk);
            #2;
            resetn = 1'b0;
            #1;
            check("abort_outputs", {read_en, read_address, busy, done, axis.tvalid,
                                    axis.tlast, axis.tdata}, 0);
            repeat (3) begin
               @(negedge clk);
               check("abort_no_done", done, 0);
            end
            resetn   = 1'b1;
            finished = 1;
            aborted  = 1;
         end
      end
      check("burst_finished", finished, 1);
      if (mode == 0 && cnt > 0 && !aborted) check("first_tvalid_cycle", first_valid, 3);
   endtask

   initial begin
      resetn       = 1'b0;
      start        = 1'b0;
      base_address = '0;
      count        = '0;
      axis.tready  = 1'b0;
      ram_q        = '0;
      ram[0] = 8'h11; ram[1] = 8'h22; ram[2] = 8'h33; ram[3] = 8'h44;
      #1;
      check("reset_outputs", {read_en, read_address, busy, done, axis.tvalid,
                              axis.tlast, axis.tdata}, 0);
      @(negedge clk);
      resetn = 1'b1;

      run_burst(0, 4, 0, 0, -1);
      run_burst(0, 4, 1, 0, -1);
      run_burst(3, 3, 0, 0, -1);
      run_burst(0, 0, 0, 0, -1);
      run_burst(0, 4, 0, 1, -1);
      run_burst(0, 4, 0, 0, 2);
      run_burst(0, 2, 0, 0, -1);
      run_burst(0, 4, 3, 0, -1);

      for (int n = 0; n < 25; n++) begin
         for (int a = 0; a < 4; a++) ram[a] = 8'($urandom);
         run_burst(int'($urandom_range(0, 3)), int'($urandom_range(0, 4)), 2, 0, -1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
